// File: rtl/accel_dot_pkg.sv
// Shared types for the lane-parallel dot-product accelerator: FSM states and
// accumulator width helper.
package accel_dot_pkg;

  typedef enum logic [1:0] {
    S_LOAD,
    S_FLUSH,
    S_COMP,
    S_OUT
  } state_t;

  // Full-precision product plus headroom for summing every column of a row.
  function automatic int unsigned acc_width(input int unsigned data_w,
                                            input int unsigned cols);
    return 2 * data_w + $clog2(cols);
  endfunction

endpackage

// File: rtl/dot_lane.sv
// One multiply-accumulate lane: acc <= (clr ? 0 : acc) + (x*w >>> FRAC_BITS)
// whenever en is high.
module dot_lane #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned FRAC_BITS = 16,
  parameter int unsigned ACC_W     = 66
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] w,
  output logic [ACC_W-1:0]  acc
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [2*DATA_W-1:0] prod_sh;
  logic signed [ACC_W-1:0]    term;

  always_comb begin
    prod    = (2*DATA_W)'(signed'(x)) * (2*DATA_W)'(signed'(w));
    prod_sh = prod >>> FRAC_BITS;
    term    = ACC_W'(prod_sh);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (en) begin
      acc <= clr ? term : acc + term;
    end
  end

endmodule

// File: rtl/accel_dot_lanes.sv
// Lane-parallel y = W*x accelerator with AXI4-Stream in/out and framing recovery.
// Define ACCEL_DOT_LANES_SAT_EN to saturate results instead of wrapping.
module accel_dot_lanes
  import accel_dot_pkg::*;
#(
  parameter int unsigned ROWS      = 3,
  parameter int unsigned COLS      = 4,
  parameter int unsigned LANES     = 2,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned FRAC_BITS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] INPUT_AXIS_TDATA,
  input  logic              INPUT_AXIS_TLAST,
  input  logic              INPUT_AXIS_TVALID,
  output logic              INPUT_AXIS_TREADY,
  input  logic [DATA_W-1:0] weights [0:ROWS-1][0:COLS-1],
  output logic [DATA_W-1:0] OUTPUT_AXIS_TDATA,
  output logic              OUTPUT_AXIS_TLAST,
  output logic              OUTPUT_AXIS_TVALID,
  input  logic              OUTPUT_AXIS_TREADY,
  output logic              frame_err,
  output logic              busy
);

  localparam int unsigned K     = COLS / LANES;
  localparam int unsigned ACC_W = acc_width(DATA_W, COLS);
  localparam int unsigned IDX_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned K_W   = $clog2(K + 1);

  if (LANES == 0 || LANES > COLS || (COLS % LANES) != 0) begin : g_bad_cfg
    $error("accel_dot_lanes: COLS must be a non-zero multiple of LANES");
  end

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(COLS - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [K_W-1:0]   K_END    = K_W'(K);

`ifdef ACCEL_DOT_LANES_SAT_EN
  localparam logic [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
`endif

  function automatic logic [DATA_W-1:0] reduce(input logic [ACC_W-1:0] s);
`ifdef ACCEL_DOT_LANES_SAT_EN
    if ($signed(s) > $signed(SAT_MAX))      return SAT_MAX[DATA_W-1:0];
    else if ($signed(s) < $signed(SAT_MIN)) return SAT_MIN[DATA_W-1:0];
    else                                    return s[DATA_W-1:0];
`else
    return s[DATA_W-1:0];
`endif
  endfunction

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [ROW_W-1:0]   row;
  logic [K_W-1:0]     k;
  logic [DATA_W-1:0]  x_buf [COLS];

  logic               lane_en;
  logic               lane_clr;
  logic [K_W-1:0]     k_sel;
  logic [IDX_W-1:0]   col [LANES];
  logic [DATA_W-1:0]  lane_x [LANES];
  logic [DATA_W-1:0]  lane_w [LANES];
  logic [ACC_W-1:0]   lane_acc [LANES];
  logic [ACC_W-1:0]   tree_sum;

  // k == K is the adder-tree cycle; lanes idle, so their operand index is parked at 0.
  always_comb begin
    lane_en  = (state == S_COMP) && (k != K_END);
    lane_clr = (k == '0);
    k_sel    = (k == K_END) ? '0 : k;
    for (int unsigned l = 0; l < LANES; l++) begin
      col[l]    = IDX_W'(l * K + 32'(k_sel));
      lane_x[l] = x_buf[col[l]];
      lane_w[l] = weights[row][col[l]];
    end
  end

  always_comb begin
    tree_sum = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      tree_sum = tree_sum + lane_acc[l];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    dot_lane #(
      .DATA_W   (DATA_W),
      .FRAC_BITS(FRAC_BITS),
      .ACC_W    (ACC_W)
    ) u_lane (
      .clk(clk),
      .rst(rst),
      .clr(lane_clr),
      .en (lane_en),
      .x  (lane_x[l]),
      .w  (lane_w[l]),
      .acc(lane_acc[l])
    );
  end

  assign busy = !((state == S_LOAD) && (idx == '0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state              <= S_LOAD;
      idx                <= '0;
      row                <= '0;
      k                  <= '0;
      INPUT_AXIS_TREADY  <= 1'b0;
      OUTPUT_AXIS_TVALID <= 1'b0;
      OUTPUT_AXIS_TLAST  <= 1'b0;
      OUTPUT_AXIS_TDATA  <= '0;
      frame_err          <= 1'b0;
      for (int unsigned i = 0; i < COLS; i++) x_buf[IDX_W'(i)] <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          INPUT_AXIS_TREADY <= 1'b1;
          if (INPUT_AXIS_TREADY && INPUT_AXIS_TVALID) begin
            x_buf[idx] <= INPUT_AXIS_TDATA;
            if (INPUT_AXIS_TLAST) begin
              if (idx != LAST_IDX) begin
                frame_err <= 1'b1;
                for (int unsigned i = 0; i < COLS; i++)
                  if (i > 32'(idx)) x_buf[IDX_W'(i)] <= '0;
              end
              INPUT_AXIS_TREADY <= 1'b0;
              idx               <= '0;
              row               <= '0;
              k                 <= '0;
              state             <= S_COMP;
            end else if (idx == LAST_IDX) begin
              frame_err <= 1'b1;
              idx       <= '0;
              state     <= S_FLUSH;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        S_FLUSH: begin
          if (INPUT_AXIS_TREADY && INPUT_AXIS_TVALID && INPUT_AXIS_TLAST) begin
            INPUT_AXIS_TREADY <= 1'b0;
            row               <= '0;
            k                 <= '0;
            state             <= S_COMP;
          end
        end
        S_COMP: begin
          if (k != K_END) begin
            k <= k + 1'b1;
          end else begin
            OUTPUT_AXIS_TDATA  <= reduce(tree_sum);
            OUTPUT_AXIS_TVALID <= 1'b1;
            OUTPUT_AXIS_TLAST  <= (row == LAST_ROW);
            state              <= S_OUT;
          end
        end
        S_OUT: begin
          if (OUTPUT_AXIS_TREADY) begin
            OUTPUT_AXIS_TVALID <= 1'b0;
            OUTPUT_AXIS_TLAST  <= 1'b0;
            if (row == LAST_ROW) begin
              INPUT_AXIS_TREADY <= 1'b1;
              idx               <= '0;
              state             <= S_LOAD;
            end else begin
              row   <= row + 1'b1;
              k     <= '0;
              state <= S_COMP;
            end
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_accel_dot_lanes.sv
// Directed bench for accel_dot_lanes: 3x4/2-lane instance plus a 16-bit 1x4
// instance for the wrap/saturate corner.
module tb_accel_dot_lanes;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] a_in_data;
  logic        a_in_last, a_in_valid, a_in_ready;
  logic [31:0] a_w [0:2][0:3];
  logic [31:0] a_out_data;
  logic        a_out_last, a_out_valid, a_out_ready;
  logic        a_frame_err, a_busy;

  logic [15:0] b_in_data;
  logic        b_in_last, b_in_valid, b_in_ready;
  logic [15:0] b_w [0:0][0:3];
  logic [15:0] b_out_data;
  logic        b_out_last, b_out_valid, b_out_ready;
  logic        b_frame_err, b_busy;

  accel_dot_lanes #(
    .ROWS(3), .COLS(4), .LANES(2), .DATA_W(32), .FRAC_BITS(0)
  ) u_dut_a (
    .clk(clk), .rst(rst),
    .INPUT_AXIS_TDATA(a_in_data), .INPUT_AXIS_TLAST(a_in_last),
    .INPUT_AXIS_TVALID(a_in_valid), .INPUT_AXIS_TREADY(a_in_ready),
    .weights(a_w),
    .OUTPUT_AXIS_TDATA(a_out_data), .OUTPUT_AXIS_TLAST(a_out_last),
    .OUTPUT_AXIS_TVALID(a_out_valid), .OUTPUT_AXIS_TREADY(a_out_ready),
    .frame_err(a_frame_err), .busy(a_busy)
  );

  accel_dot_lanes #(
    .ROWS(1), .COLS(4), .LANES(2), .DATA_W(16), .FRAC_BITS(0)
  ) u_dut_b (
    .clk(clk), .rst(rst),
    .INPUT_AXIS_TDATA(b_in_data), .INPUT_AXIS_TLAST(b_in_last),
    .INPUT_AXIS_TVALID(b_in_valid), .INPUT_AXIS_TREADY(b_in_ready),
    .weights(b_w),
    .OUTPUT_AXIS_TDATA(b_out_data), .OUTPUT_AXIS_TLAST(b_out_last),
    .OUTPUT_AXIS_TVALID(b_out_valid), .OUTPUT_AXIS_TREADY(b_out_ready),
    .frame_err(b_frame_err), .busy(b_busy)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [31:0] d, input logic last);
    int unsigned t = 0;
    a_in_data  = d;
    a_in_last  = last;
    a_in_valid = 1'b1;
    while (!a_in_ready && t < 50) begin
      tick();
      t++;
    end
    if (t >= 50) check_val("in_ready_timeout", 32'(a_in_ready), 32'd1);
    tick();
    a_in_valid = 1'b0;
    a_in_last  = 1'b0;
  endtask

  task automatic recv_a(input string tag, input logic [31:0] exp, input logic exp_last,
                        input int unsigned stall);
    int unsigned t = 0;
    a_out_ready = 1'b0;
    while (!a_out_valid && t < 50) begin
      tick();
      t++;
    end
    check_val({tag, "_valid"}, 32'(a_out_valid), 32'd1);
    for (int unsigned i = 0; i < stall; i++) begin
      tick();
      check_val({tag, "_stall_data"}, a_out_data, exp);
      check_val({tag, "_stall_last"}, 32'(a_out_last), 32'(exp_last));
      check_val({tag, "_stall_valid"}, 32'(a_out_valid), 32'd1);
      check_val({tag, "_stall_in_ready"}, 32'(a_in_ready), 32'd0);
    end
    check_val({tag, "_data"}, a_out_data, exp);
    check_val({tag, "_last"}, 32'(a_out_last), 32'(exp_last));
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
  endtask

  task automatic send_vec_a();
    send_a(32'd1, 1'b0);
    send_a(32'd1, 1'b0);
    send_a(32'd2, 1'b0);
    send_a(32'd2, 1'b1);
  endtask

  task automatic check_reset_outs(input string tag);
    check_val({tag, "_in_ready"},  32'(a_in_ready),  32'd0);
    check_val({tag, "_out_valid"}, 32'(a_out_valid), 32'd0);
    check_val({tag, "_out_last"},  32'(a_out_last),  32'd0);
    check_val({tag, "_out_data"},  a_out_data,       32'd0);
    check_val({tag, "_frame_err"}, 32'(a_frame_err), 32'd0);
    check_val({tag, "_busy"},      32'(a_busy),      32'd0);
  endtask

  initial begin
    int unsigned cnt;
    int unsigned t;
    logic [15:0] exp_b;

    rst = 1'b0;
    a_in_data = '0; a_in_last = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0;
    b_in_data = '0; b_in_last = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0;
    a_w[0] = '{32'd1, 32'd2, 32'd3, 32'd4};
    a_w[1] = '{32'd5, 32'd6, 32'd7, 32'd8};
    a_w[2] = '{32'hFFFF_FFFF, 32'd0, 32'd1, 32'd0};
    b_w[0] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};

    tick();
    tick();
    check_reset_outs("por");
    rst = 1'b1;
    tick();
    check_val("ready_after_release", 32'(a_in_ready), 32'd1);

    // Nominal vector, latency from last input beat to first result
    send_vec_a();
    cnt = 0;
    while (!a_out_valid && cnt < 20) begin
      tick();
      cnt++;
    end
    check_val("first_latency", cnt, 32'd3);
    check_val("busy_in_out", 32'(a_busy), 32'd1);
    recv_a("n_y0", 32'd17, 1'b0, 0);
    recv_a("n_y1", 32'd41, 1'b0, 0);
    recv_a("n_y2", 32'd1,  1'b1, 0);
    check_val("n_ready_after_last", 32'(a_in_ready), 32'd1);
    check_val("n_frame_err", 32'(a_frame_err), 32'd0);

    // Back-pressure on every output word
    send_vec_a();
    recv_a("s_y0", 32'd17, 1'b0, 10);
    recv_a("s_y1", 32'd41, 1'b0, 10);
    recv_a("s_y2", 32'd1,  1'b1, 10);
    check_val("s_ready_after_last", 32'(a_in_ready), 32'd1);

    // Early TLAST: missing columns must read as zero, not stale data
    send_a(32'd1, 1'b0);
    send_a(32'd1, 1'b1);
    check_val("e_frame_err", 32'(a_frame_err), 32'd1);
    recv_a("e_y0", 32'd3,         1'b0, 0);
    recv_a("e_y1", 32'd11,        1'b0, 0);
    recv_a("e_y2", 32'hFFFF_FFFF, 1'b1, 0);

    // Reset in the middle of a load discards everything
    send_a(32'd5, 1'b0);
    send_a(32'd7, 1'b0);
    rst = 1'b0;
    #1;
    check_reset_outs("mid_rst_async");
    tick();
    check_reset_outs("mid_rst_held");
    rst = 1'b1;
    tick();
    send_vec_a();
    recv_a("r_y0", 32'd17, 1'b0, 0);
    recv_a("r_y1", 32'd41, 1'b0, 0);
    recv_a("r_y2", 32'd1,  1'b1, 0);
    check_val("r_frame_err", 32'(a_frame_err), 32'd0);

    // Overlong vector: beats 5-6 discarded
    send_a(32'd2, 1'b0);
    send_a(32'd1, 1'b0);
    send_a(32'd1, 1'b0);
    send_a(32'd1, 1'b0);
    check_val("o_frame_err", 32'(a_frame_err), 32'd1);
    check_val("o_flush_ready", 32'(a_in_ready), 32'd1);
    check_val("o_flush_busy", 32'(a_busy), 32'd1);
    send_a(32'd9, 1'b0);
    check_val("o_flush_no_out", 32'(a_out_valid), 32'd0);
    send_a(32'd9, 1'b1);
    recv_a("o_y0", 32'd11,        1'b0, 0);
    recv_a("o_y1", 32'd31,        1'b0, 0);
    recv_a("o_y2", 32'hFFFF_FFFF, 1'b1, 0);

    // 16-bit instance: 4*32767^2 = 0xFFFC0004
`ifdef ACCEL_DOT_LANES_SAT_EN
    exp_b = 16'h7FFF;
`else
    exp_b = 16'h0004;
`endif
    for (int unsigned i = 0; i < 4; i++) begin
      b_in_data  = 16'h7FFF;
      b_in_last  = (i == 3);
      b_in_valid = 1'b1;
      t = 0;
      while (!b_in_ready && t < 50) begin
        tick();
        t++;
      end
      if (t >= 50) check_val("b_in_ready_timeout", 32'(b_in_ready), 32'd1);
      tick();
      b_in_valid = 1'b0;
      b_in_last  = 1'b0;
    end
    t = 0;
    while (!b_out_valid && t < 50) begin
      tick();
      t++;
    end
    check_val("b_valid", 32'(b_out_valid), 32'd1);
    check_val("b_data", 32'(b_out_data), 32'(exp_b));
    check_val("b_last", 32'(b_out_last), 32'd1);
    check_val("b_frame_err", 32'(b_frame_err), 32'd0);
    b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0;
    check_val("b_ready_after_last", 32'(b_in_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
